carry_skip_adder_pipe: RTL and testbench

Parametrised, pipelined carry-skip adder with a valid/ready stream interface. It is the next-generation replacement for the fixed 32-bit, 8-bit-block combinational carry-skip adder in the datapath. Width, block size and pipeline depth are generics, and full backpressure is supported. Result, carry-out and signed overflow emerge a fixed number of cycles after acceptance.

---
 rtl/carry_skip_adder_pipe_pkg.sv | 27 ++
 rtl/carry_skip_adder_pipe_if.sv | 35 +++
 rtl/carry_skip_adder_pipe_skip_block.sv | 29 ++
 rtl/carry_skip_adder_pipe.sv | 125 ++++++++++++
 tb/tb_carry_skip_adder_pipe.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/carry_skip_adder_pipe_pkg.sv
// Shared helpers for the pipelined carry-skip adder: block/stage geometry,
// legality check and the per-stage control payload.
package csa_pipe_pkg;

  function automatic int csa_nblk(input int width, input int block);
    return (block > 0) ? width / block : 0;
  endfunction

  function automatic int csa_bps(input int width, input int block, input int stages);
    return (stages > 0) ? csa_nblk(width, block) / stages : 0;
  endfunction

  function automatic bit csa_legal(input int width, input int block, input int stages);
    if (block < 1 || stages < 1 || width < block) return 1'b0;
    if ((width % block) != 0) return 1'b0;
    return (csa_nblk(width, block) % stages) == 0;
  endfunction

  // Carried alongside the partial sum: carry into the next stage plus the
  // operand MSBs needed for the overflow flag at the output.
  typedef struct packed {
    logic carry;
    logic a_msb;
    logic b_msb;
  } csa_ctl_t;

endpackage

// File: rtl/carry_skip_adder_pipe_if.sv
// Stream bundle of the pipelined carry-skip adder; sub exists only when
// CSA_PIPE_SUB_EN is defined.
interface carry_skip_adder_pipe_if #(parameter int WIDTH = 32);
  // Handshake: a beat moves on a rising edge where valid && ready; once valid
  // is raised, it and its payload hold until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CSA_PIPE_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             of;

  modport master (
`ifdef CSA_PIPE_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, of
  );

  modport slave (
`ifdef CSA_PIPE_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, of
  );
endinterface

// File: rtl/carry_skip_adder_pipe_skip_block.sv
// One BLOCK-bit ripple adder whose carry-out is bypassed by the block
// carry-in whenever every bit propagates.
module csa_skip_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_cin,
  output logic [BLOCK-1:0] o_sum,
  output logic             o_cout
);
  logic [BLOCK-1:0] w_p;
  logic             w_rip;

  assign w_p = i_a ^ i_b;

  always_comb begin
    logic c;
    o_sum = '0;
    c     = i_cin;
    for (int i = 0; i < BLOCK; i++) begin
      o_sum[i] = w_p[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & w_p[i]);
    end
    w_rip = c;
  end

  assign o_cout = (&w_p) ? i_cin : w_rip;
endmodule

// File: rtl/carry_skip_adder_pipe.sv
// Pipelined carry-skip adder: stage k sums blocks k*BPS..(k+1)*BPS-1 and
// forwards untouched upper operands. Optional subtract mode: CSA_PIPE_SUB_EN.
module carry_skip_adder_pipe
  import csa_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 8,
  parameter int STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  carry_skip_adder_pipe_if.slave  io_bus
);
  localparam int NBLK = csa_nblk(WIDTH, BLOCK);
  localparam int BPS  = csa_bps(WIDTH, BLOCK, STAGES);
  localparam int SW   = BPS * BLOCK;

  if (!csa_legal(WIDTH, BLOCK, STAGES) || NBLK < 1) begin : g_illegal
    $fatal(1, "carry_skip_adder_pipe: WIDTH/BLOCK/STAGES combination is illegal");
  end

  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [STAGES:0]  w_ready;

`ifdef CSA_PIPE_SUB_EN
  assign w_sub = io_bus.sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_b_eff         = io_bus.b ^ {WIDTH{w_sub}};
  assign w_cin_eff       = io_bus.cin ^ w_sub;
  assign w_ready[STAGES] = io_bus.out_ready;
  assign io_bus.in_ready = w_ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SW;
    localparam int HI = (k + 1) * SW;

    logic [WIDTH-1:LO] w_src_a;
    logic [WIDTH-1:LO] w_src_b;
    logic              w_vin;
    logic              w_a_msb;
    logic              w_b_msb;
    logic [BPS:0]      w_c;
    logic [SW-1:0]     w_s;
    logic              r_valid;
    csa_ctl_t          r_ctl;
    logic [HI-1:0]     r_sum;

    if (k == 0) begin : g_head
      assign w_src_a = io_bus.a;
      assign w_src_b = w_b_eff;
      assign w_c[0]  = w_cin_eff;
      assign w_vin   = io_bus.in_valid;
      assign w_a_msb = io_bus.a[WIDTH-1];
      assign w_b_msb = w_b_eff[WIDTH-1];
    end else begin : g_tail
      assign w_src_a = g_st[k-1].g_fwd.r_a;
      assign w_src_b = g_st[k-1].g_fwd.r_b;
      assign w_c[0]  = g_st[k-1].r_ctl.carry;
      assign w_vin   = g_st[k-1].r_valid;
      assign w_a_msb = g_st[k-1].r_ctl.a_msb;
      assign w_b_msb = g_st[k-1].r_ctl.b_msb;
    end

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      csa_skip_block #(.BLOCK(BLOCK)) u_blk (
        .i_a    (w_src_a[LO + j*BLOCK +: BLOCK]),
        .i_b    (w_src_b[LO + j*BLOCK +: BLOCK]),
        .i_cin  (w_c[j]),
        .o_sum  (w_s[j*BLOCK +: BLOCK]),
        .o_cout (w_c[j+1])
      );
    end

    // A stage may load when it is empty or its content moves on this edge.
    assign w_ready[k] = !r_valid || w_ready[k+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_ctl   <= '0;
      end else if (w_ready[k]) begin
        r_valid     <= w_vin;
        r_ctl.carry <= w_c[BPS];
        r_ctl.a_msb <= w_a_msb;
        r_ctl.b_msb <= w_b_msb;
      end
    end

    if (k == 0) begin : g_sum0
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_sum <= '0;
        else if (w_ready[k]) r_sum <= w_s;
      end
    end else begin : g_sumk
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_sum <= '0;
        else if (w_ready[k]) r_sum <= {w_s, g_st[k-1].r_sum};
      end
    end

    if (k == STAGES - 1) begin : g_out
      assign io_bus.out_valid = r_valid;
      assign io_bus.sum       = r_sum;
      assign io_bus.cout      = r_ctl.carry;
      assign io_bus.of        = (r_ctl.a_msb == r_ctl.b_msb) && (r_sum[WIDTH-1] != r_ctl.a_msb);
    end else begin : g_fwd
      logic [WIDTH-1:HI] r_a;
      logic [WIDTH-1:HI] r_b;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_ready[k]) begin
          r_a <= w_src_a[WIDTH-1:HI];
          r_b <= w_src_b[WIDTH-1:HI];
        end
      end
    end
  end
endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// Directed bench for carry_skip_adder_pipe (WIDTH=32, BLOCK=8, STAGES=2),
// including the CSA_PIPE_SUB_EN subtract case when that macro is defined.
module tb_carry_skip_adder_pipe;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [33:0] exp_q[$];

  carry_skip_adder_pipe_if #(.WIDTH(32)) bus ();

  carry_skip_adder_pipe #(.WIDTH(32), .BLOCK(8), .STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // hand-computed vectors: a, b, cin -> sum, cout, of
  logic [31:0] tv_a  [10] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFF00FF00, 32'hFF00FF00,
                              32'h00000080, 32'h12345678, 32'h0000FFFF, 32'h80000000, 32'h00FFFFFF};
  logic [31:0] tv_b  [10] = '{32'h00000000, 32'h00000001, 32'h80000000, 32'h00FF00FF, 32'h00FF00FF,
                              32'h0000007F, 32'h9ABCDEF0, 32'h0000FFFF, 32'hFFFFFFFF, 32'h00000001};
  logic        tv_c  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] tv_es [10] = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF,
                              32'h00000100, 32'hACF13568, 32'h0001FFFF, 32'h7FFFFFFF, 32'h01000000};
  logic        tv_ec [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        tv_eo [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // driver tasks
  task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
    bus.a        = ta;
    bus.b        = tb;
    bus.cin      = tc;
    bus.in_valid = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] es, input logic ec, input logic eo);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_sum"},   64'(bus.sum),       64'(es));
    chk({tag, "_cout"},  64'(bus.cout),      64'(ec));
    chk({tag, "_of"},    64'(bus.of),        64'(eo));
  endtask

  // one operation on an empty pipe; result must appear exactly two edges later
  task automatic single(input string tag, input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                        input logic [31:0] es, input logic ec, input logic eo);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    drive(ta, tb, tc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk_out(tag, es, ec, eo);
  endtask

  // back-to-back stream with out_ready=1; scoreboard via exp_q
  task automatic stream_run(input string tag, input int n, input bit rnd);
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] full;
    logic [33:0] exp;
    bus.out_ready = 1'b1;
    for (int t = 0; t < n + 2; t++) begin
      @(negedge clk);
      if (t >= 2) begin
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        if (bus.out_valid && exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          chk({tag, "_result"}, 64'({bus.of, bus.cout, bus.sum}), 64'(exp));
        end
      end
      if (t < n) begin
        if (rnd) begin
          ra   = $urandom;
          rb   = $urandom;
          rc   = 1'($urandom_range(1, 0));
          full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
          exp  = {(ra[31] == rb[31]) && (full[31] != ra[31]), full};
        end else begin
          ra  = tv_a[t];
          rb  = tv_b[t];
          rc  = tv_c[t];
          exp = {tv_eo[t], tv_ec[t], tv_es[t]};
        end
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        drive(ra, rb, rc);
        exp_q.push_back(exp);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
`ifdef CSA_PIPE_SUB_EN
    bus.sub       = 1'b0;
`endif
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum",       64'(bus.sum),       64'd0);
    chk("rst_cout",      64'(bus.cout),      64'd0);
    chk("rst_of",        64'(bus.of),        64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    single("skip_chain", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    single("overflow",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    single("stage_cross", 32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0);

    // backpressure: three back-to-back adds against a stalled output
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(32'h1, 32'h1, 1'b0);
    @(negedge clk);
    chk("bp_in_ready_1", 64'(bus.in_ready), 64'd1);
    drive(32'h2, 32'h2, 1'b0);
    @(negedge clk);
    drive(32'h3, 32'h3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_in_ready_0", 64'(bus.in_ready),  64'd0);
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_sum",   64'(bus.sum),       64'h2);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("bp_res2", 32'h4, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("bp_res3", 32'h6, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    stream_run("table", 10, 1'b0);
    stream_run("random", 100, 1'b1);

`ifdef CSA_PIPE_SUB_EN
    bus.sub = 1'b1;
    single("sub_5_7", 32'h5, 32'h7, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
    bus.sub = 1'b0;
`endif

    // reset with a held result and a second op in flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(32'h80000000, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    drive(32'h1, 32'h1, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("pre_rst", 32'h7FFFFFFF, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_sum",       64'(bus.sum),       64'd0);
    chk("mid_rst_cout",      64'(bus.cout),      64'd0);
    chk("mid_rst_of",        64'(bus.of),        64'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(bus.out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
